pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS32 pipeline.
- Drives the FREEZE/FLUSH controls of the IF/ID register and the freeze/bubble controls of the PC, ID/EX and EX/MEM registers.
- Resolves load-use hazards, taken-branch flushes, multi-cycle mul/div occupancy and data-memory wait states.
- Runs a small FSM plus a wait-timeout counter.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- TIMEOUT_CYCLES, 255, maximum consecutive DMEM_BUSY cycles before the timeout error is flagged.
- TMO_W, 8, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- ID_SRC1  in  REG_ADDR_W  rs of the instruction in ID.
- ID_SRC2  in  REG_ADDR_W  rt of the instruction in ID.
- ID_TWO_SRC  in  1  ID instruction actually reads ID_SRC2.
- EX_DEST  in  REG_ADDR_W  destination register of the instruction in EX.
- EX_MEM_READ  in  1  EX instruction is a load.
- BRANCH_TAKEN  in  1  branch resolved taken in EX this cycle.
- MD_START  in  1  mul/div issued from EX this cycle (single-cycle pulse).
- MD_DONE  in  1  mul/div result valid; level, held until consumed.
- DMEM_BUSY  in  1  data memory not ready; MEM stage must hold.
- PC_FREEZE  out  1  hold PC.
- IFID_FREEZE  out  1  to IF/ID FREEZE.
- IFID_FLUSH  out  1  to IF/ID FLUSH.
- IDEX_FREEZE  out  1  hold ID/EX.
- IDEX_BUBBLE  out  1  load NOP into ID/EX.
- EXMEM_FREEZE  out  1  hold EX/MEM.
- EXMEM_BUBBLE  out  1  load NOP into EX/MEM.
- TIMEOUT_ERR  out  1  sticky memory-wait timeout flag.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RESET.
- Reset state:
  - While RESET=1, all outputs are 0.
  - On the next edge: state=RUN, wait counter=0, TIMEOUT_ERR=0.
- Output timing: control outputs are Mealy (state plus current inputs), so each takes effect in the same cycle. State, counter and TIMEOUT_ERR update on the rising edge.
- States: RUN, MD_WAIT, MEM_WAIT.
- Priority, highest first: RESET > DMEM_BUSY > mul/div occupancy > BRANCH_TAKEN > load-use.
- Memory wait (DMEM_BUSY=1, any state):
  - Outputs: PC_FREEZE, IFID_FREEZE, IDEX_FREEZE and EXMEM_FREEZE = 1. All bubbles and flushes = 0.
  - Next state is MEM_WAIT; a pending MD_WAIT is remembered in a 1-bit md_pend flag.
  - Counter increments every cycle, saturating.
  - When the counter reaches TIMEOUT_CYCLES, TIMEOUT_ERR is set and stays set until reset.
- MEM_WAIT exit: the first cycle with DMEM_BUSY=0 evaluates as MD_WAIT if md_pend, otherwise as RUN. The counter clears in that cycle.
- Mul/div occupancy (MD_START=1 in RUN, or state MD_WAIT with MD_DONE=0):
  - Outputs: PC_FREEZE, IFID_FREEZE and IDEX_FREEZE = 1; EXMEM_BUBBLE=1.
  - Next state is MD_WAIT.
  - BRANCH_TAKEN and load-use are ignored.
- MD_DONE=1 in MD_WAIT:
  - No freezes asserted; EXMEM_BUBBLE=0 so the result advances.
  - Next state is RUN; RUN rules apply to the other inputs in this same cycle.
- MD_START with MD_DONE=1 in the same cycle (single-cycle op): no occupancy; state stays RUN.
- Branch (RUN, BRANCH_TAKEN=1):
  - IFID_FLUSH=1 and IDEX_BUBBLE=1.
  - IFID_FREEZE=0 and PC_FREEZE=0 (PC takes the target).
  - Suppresses any load-use stall in the same cycle.
- Load-use (RUN): asserted when EX_MEM_READ=1, EX_DEST≠0, and either ID_SRC1==EX_DEST or (ID_TWO_SRC and ID_SRC2==EX_DEST).
  - Outputs: PC_FREEZE=1, IFID_FREEZE=1, IDEX_BUBBLE=1, for exactly one cycle.
- Invariants:
  - IFID_FLUSH and IFID_FREEZE are never both 1.
  - IDEX_FREEZE and IDEX_BUBBLE are never both 1.
  - EXMEM_FREEZE and EXMEM_BUBBLE are never both 1.
- Reset mid-wait: returns to RUN; md_pend and the counter clear.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, adds three output ports of width 32: STAT_LOADUSE, STAT_MDWAIT and STAT_MEMWAIT.
  - Each counts the cycles in which the corresponding condition asserted PC_FREEZE.
  - They wrap at 2^32 and clear on RESET.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Load-use hazard: EX_MEM_READ=1, EX_DEST=5, ID_SRC1=5 for one cycle -> PC_FREEZE=IFID_FREEZE=IDEX_BUBBLE=1 that cycle only. Same stimulus with EX_DEST=0 -> all outputs 0.
- Branch beats load-use: BRANCH_TAKEN=1 together with a load-use match -> IFID_FLUSH=1, IDEX_BUBBLE=1, PC_FREEZE=0, IFID_FREEZE=0.
- Mul/div wait: MD_START pulse, then MD_DONE after 4 cycles -> freezes plus EXMEM_BUBBLE for 5 cycles (start cycle + 4); on the MD_DONE cycle all outputs 0 and the state is back in RUN.
- Memory wait during mul/div: DMEM_BUSY=1 for 3 cycles while in MD_WAIT -> all four freezes =1 with no bubbles; after DMEM_BUSY falls, MD_WAIT behaviour resumes until MD_DONE.
- Timeout: TIMEOUT_CYCLES=4 with DMEM_BUSY held 6 cycles -> TIMEOUT_ERR rises after the 4th busy edge and stays set after DMEM_BUSY drops; RESET clears it.
- Reset mid-wait: RESET asserted in MEM_WAIT -> all outputs 0 while RESET=1, then the state is RUN with the counter at 0. With HAZARD_STATS_EN defined, the STAT_* counters read 0 after reset.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS32 pipeline: load-use, branch, mul/div and DMEM wait.
// Optional per-cause freeze statistics are enabled with the HAZARD_STATS_EN macro.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W     = 5,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [REG_ADDR_W-1:0] i_id_src1,
  input  logic [REG_ADDR_W-1:0] i_id_src2,
  input  logic                  i_id_two_src,
  input  logic [REG_ADDR_W-1:0] i_ex_dest,
  input  logic                  i_ex_mem_read,
  input  logic                  i_branch_taken,
  input  logic                  i_md_start,
  input  logic                  i_md_done,
  input  logic                  i_dmem_busy,
  output logic                  o_pc_freeze,
  output logic                  o_ifid_freeze,
  output logic                  o_ifid_flush,
  output logic                  o_idex_freeze,
  output logic                  o_idex_bubble,
  output logic                  o_exmem_freeze,
  output logic                  o_exmem_bubble,
  output logic                  o_timeout_err
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]           o_stat_loaduse,
  output logic [31:0]           o_stat_mdwait,
  output logic [31:0]           o_stat_memwait
`endif
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MD_WAIT,
    ST_MEM_WAIT
  } state_t;

  state_t           r_state;
  logic             r_mdPend;
  logic [TMO_W-1:0] r_waitCnt;
  logic             r_timeoutErr;

  state_t           w_effState;
  logic             w_loadUse;
  logic             w_mdOccupied;
  logic             w_memStall;
  logic             w_mdStall;
  logic             w_branchFlush;
  logic             w_luStall;
  logic [TMO_W-1:0] w_waitCntInc;

  // Leaving MEM_WAIT behaves as whichever state the memory wait interrupted.
  always_comb begin
    w_effState = r_state;
    if (r_state == ST_MEM_WAIT) begin
      w_effState = r_mdPend ? ST_MD_WAIT : ST_RUN;
    end
  end

  assign w_loadUse = i_ex_mem_read && (i_ex_dest != '0) &&
                     ((i_id_src1 == i_ex_dest) || (i_id_two_src && (i_id_src2 == i_ex_dest)));

  // A start with done in the same cycle is a single-cycle op and never occupies the unit.
  assign w_mdOccupied = !i_md_done &&
                        ((w_effState == ST_MD_WAIT) || ((w_effState == ST_RUN) && i_md_start));

  assign w_memStall    = !i_reset && i_dmem_busy;
  assign w_mdStall     = !i_reset && !i_dmem_busy && w_mdOccupied;
  assign w_branchFlush = !i_reset && !i_dmem_busy && !w_mdOccupied && i_branch_taken;
  assign w_luStall     = !i_reset && !i_dmem_busy && !w_mdOccupied && !i_branch_taken && w_loadUse;

  assign w_waitCntInc = (r_waitCnt == {TMO_W{1'b1}}) ? r_waitCnt : r_waitCnt + 1'b1;

  always_comb begin
    o_pc_freeze    = w_memStall || w_mdStall || w_luStall;
    o_ifid_freeze  = w_memStall || w_mdStall || w_luStall;
    o_ifid_flush   = w_branchFlush;
    o_idex_freeze  = w_memStall || w_mdStall;
    o_idex_bubble  = w_branchFlush || w_luStall;
    o_exmem_freeze = w_memStall;
    o_exmem_bubble = w_mdStall;
    o_timeout_err  = !i_reset && r_timeoutErr;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_RUN;
      r_mdPend     <= 1'b0;
      r_waitCnt    <= '0;
      r_timeoutErr <= 1'b0;
    end else if (i_dmem_busy) begin
      r_state   <= ST_MEM_WAIT;
      r_mdPend  <= (w_effState == ST_MD_WAIT);
      r_waitCnt <= w_waitCntInc;
      if (w_waitCntInc >= TMO_W'(TIMEOUT_CYCLES)) begin
        r_timeoutErr <= 1'b1;
      end
    end else begin
      r_state   <= w_mdOccupied ? ST_MD_WAIT : ST_RUN;
      r_mdPend  <= 1'b0;
      r_waitCnt <= '0;
    end
  end

`ifdef HAZARD_STATS_EN
  // Each counter tracks cycles in which its own cause held the PC.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stat_loaduse <= '0;
      o_stat_mdwait  <= '0;
      o_stat_memwait <= '0;
    end else begin
      if (w_luStall)  o_stat_loaduse <= o_stat_loaduse + 32'd1;
      if (w_mdStall)  o_stat_mdwait  <= o_stat_mdwait + 32'd1;
      if (w_memStall) o_stat_memwait <= o_stat_memwait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus multi-cycle sequences.
// Output word order: {pc_frz, ifid_frz, ifid_flush, idex_frz, idex_bub, exmem_frz, exmem_bub, tmo_err}.
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_LU   = 8'b1100_1000;
  localparam logic [7:0] O_BR   = 8'b0010_1000;
  localparam logic [7:0] O_MD   = 8'b1101_0010;
  localparam logic [7:0] O_MEM  = 8'b1101_0100;
  localparam logic [7:0] O_ERR  = 8'b0000_0001;

  typedef struct packed {
    logic       rst;
    logic       busy;
    logic       mdStart;
    logic       mdDone;
    logic       branch;
    logic       memRead;
    logic [4:0] exDest;
    logic [4:0] src1;
    logic [4:0] src2;
    logic       twoSrc;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] idSrc1 = '0;
  logic [4:0] idSrc2 = '0;
  logic       idTwoSrc = 1'b0;
  logic [4:0] exDest = '0;
  logic       exMemRead = 1'b0;
  logic       branchTaken = 1'b0;
  logic       mdStart = 1'b0;
  logic       mdDone = 1'b0;
  logic       dmemBusy = 1'b0;
  logic       pcFreeze, ifidFreeze, ifidFlush, idexFreeze, idexBubble;
  logic       exmemFreeze, exmemBubble, timeoutErr;
`ifdef HAZARD_STATS_EN
  logic [31:0] statLoadUse, statMdWait, statMemWait;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] expQ[$];
  vec_t       tbl[12];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_ADDR_W(5),
    .TIMEOUT_CYCLES(4),
    .TMO_W(8)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_id_src1(idSrc1),
    .i_id_src2(idSrc2),
    .i_id_two_src(idTwoSrc),
    .i_ex_dest(exDest),
    .i_ex_mem_read(exMemRead),
    .i_branch_taken(branchTaken),
    .i_md_start(mdStart),
    .i_md_done(mdDone),
    .i_dmem_busy(dmemBusy),
    .o_pc_freeze(pcFreeze),
    .o_ifid_freeze(ifidFreeze),
    .o_ifid_flush(ifidFlush),
    .o_idex_freeze(idexFreeze),
    .o_idex_bubble(idexBubble),
    .o_exmem_freeze(exmemFreeze),
    .o_exmem_bubble(exmemBubble),
    .o_timeout_err(timeoutErr)
`ifdef HAZARD_STATS_EN
    ,
    .o_stat_loaduse(statLoadUse),
    .o_stat_mdwait(statMdWait),
    .o_stat_memwait(statMemWait)
`endif
  );

  function automatic vec_t mkFull(input logic rst, input logic busy, input logic mdS,
                                  input logic mdD, input logic br, input logic memRd,
                                  input logic [4:0] dest, input logic [4:0] s1,
                                  input logic [4:0] s2, input logic two, input logic [7:0] exp);
    vec_t v;
    v.rst = rst; v.busy = busy; v.mdStart = mdS; v.mdDone = mdD; v.branch = br;
    v.memRead = memRd; v.exDest = dest; v.src1 = s1; v.src2 = s2; v.twoSrc = two;
    v.exp = exp;
    return v;
  endfunction

  // lu=1 sets up a load to r5 in EX with r5 read by the ID instruction.
  function automatic vec_t mk(input logic rst, input logic busy, input logic mdS,
                              input logic mdD, input logic br, input logic lu,
                              input logic [7:0] exp);
    return mkFull(rst, busy, mdS, mdD, br, lu, lu ? 5'd5 : 5'd0, lu ? 5'd5 : 5'd0,
                  5'd0, 1'b0, exp);
  endfunction

  task automatic checkOutput(input string name);
    logic [7:0] exp;
    logic [7:0] act;
    exp = expQ.pop_front();
    act = {pcFreeze, ifidFreeze, ifidFlush, idexFreeze, idexBubble,
           exmemFreeze, exmemBubble, timeoutErr};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    @(posedge clk);
    #1;
    reset       = v.rst;
    dmemBusy    = v.busy;
    mdStart     = v.mdStart;
    mdDone      = v.mdDone;
    branchTaken = v.branch;
    exMemRead   = v.memRead;
    exDest      = v.exDest;
    idSrc1      = v.src1;
    idSrc2      = v.src2;
    idTwoSrc    = v.twoSrc;
    expQ.push_back(v.exp);
    @(negedge clk);
    checkOutput(name);
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 1, O_NONE);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, O_NONE);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1, O_LU);
    tbl[3]  = mkFull(0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1'b0, O_NONE);
    tbl[4]  = mkFull(0, 0, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1'b1, O_LU);
    tbl[5]  = mkFull(0, 0, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1'b0, O_NONE);
    tbl[6]  = mkFull(0, 0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd0, 1'b0, O_NONE);
    tbl[7]  = mk(0, 0, 0, 0, 1, 1, O_BR);
    tbl[8]  = mk(0, 0, 0, 0, 1, 0, O_BR);
    tbl[9]  = mk(0, 0, 1, 1, 0, 0, O_NONE);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, O_LU);
    tbl[11] = mkFull(0, 0, 0, 0, 0, 1, 5'd5, 5'd6, 5'd5, 1'b0, O_NONE);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i], $sformatf("vec%0d", i));
    end

    // Mul/div: start plus four waiting cycles, then done releases everything.
    applyStimulus(mk(0, 0, 1, 0, 0, 0, O_MD), "md_start");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, O_MD), "md_wait1");
    applyStimulus(mk(0, 0, 0, 0, 1, 1, O_MD), "md_wait2_ignore_br_lu");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, O_MD), "md_wait3");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, O_MD), "md_wait4");
    applyStimulus(mk(0, 0, 0, 1, 0, 0, O_NONE), "md_done");
    applyStimulus(mk(0, 0, 0, 0, 0, 1, O_LU), "md_after_run_lu");

    applyStimulus(mk(0, 0, 1, 0, 0, 0, O_MD), "md2_start");
    applyStimulus(mk(0, 0, 0, 1, 1, 0, O_BR), "md2_done_branch");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, O_NONE), "md2_idle");

    // Memory wait interrupting a mul/div wait must resume it afterwards.
    applyStimulus(mk(0, 0, 1, 0, 0, 0, O_MD), "mdmem_start");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, O_MD), "mdmem_wait");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM), "mdmem_busy1");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM), "mdmem_busy2");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM), "mdmem_busy3");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, O_MD), "mdmem_resume1");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, O_MD), "mdmem_resume2");
    applyStimulus(mk(0, 0, 0, 1, 0, 0, O_NONE), "mdmem_done");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, O_NONE), "mdmem_idle");

    applyStimulus(mk(0, 1, 0, 0, 0, 1, O_MEM), "mem_busy1");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM), "mem_busy2");
    applyStimulus(mk(0, 0, 0, 0, 0, 1, O_LU), "mem_exit_run_lu");

    // Timeout: error appears after the fourth busy edge and is sticky until reset.
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM), "tmo_busy1");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM), "tmo_busy2");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM), "tmo_busy3");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM), "tmo_busy4");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM | O_ERR), "tmo_busy5");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM | O_ERR), "tmo_busy6");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, O_ERR), "tmo_sticky");
    applyStimulus(mk(0, 0, 0, 0, 0, 1, O_LU | O_ERR), "tmo_sticky_lu");
    applyStimulus(mk(1, 0, 0, 0, 0, 0, O_NONE), "tmo_reset");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, O_NONE), "tmo_cleared");

    // Reset in MEM_WAIT drops md_pend and the wait counter.
    applyStimulus(mk(0, 0, 1, 0, 0, 0, O_MD), "rst_md_start");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM), "rst_busy1");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM), "rst_busy2");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM), "rst_busy3");
    applyStimulus(mk(1, 1, 0, 0, 1, 1, O_NONE), "rst_during_wait");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, O_NONE), "rst_back_in_run");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM), "rst_cnt_busy1");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM), "rst_cnt_busy2");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM), "rst_cnt_busy3");
    applyStimulus(mk(0, 1, 0, 0, 0, 0, O_MEM), "rst_cnt_busy4");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, O_ERR), "rst_cnt_err");
    applyStimulus(mk(1, 0, 0, 0, 0, 0, O_NONE), "final_reset");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, O_NONE), "final_idle");

`ifdef HAZARD_STATS_EN
    checks++;
    if ({statLoadUse, statMdWait, statMemWait} !== 96'd0) begin
      errors++;
      $display("[TB] FAIL stats_after_reset: got %0d/%0d/%0d expected 0/0/0",
               statLoadUse, statMdWait, statMemWait);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
